// File: rtl/task_responder.sv
// task_responder: worker-side engine of the clock-domain task handshake.
// A one-cycle start pulse launches a counted burst of data beats on a
// valid/ready stream. Each beat carries the seed plus the beat index. A
// one-cycle done pulse follows the last accepted beat. Everything runs in
// the destination clock domain.
//
// Optional build macro: TASK_RESP_TIMEOUT_EN
//   When it is defined, a burst that stays stalled for TIMEOUT consecutive
//   cycles is aborted. The block still emits its normal done pulse and sets
//   the sticky task_error flag. When it is undefined, the stall counter and
//   the task_error port do not exist.
module task_responder #(
   parameter int LEN_W   = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              task_start,
   input  logic [LEN_W-1:0]  task_len,
   input  logic [DATA_W-1:0] task_seed,
   output logic              task_busy,
   output logic              task_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              start_overrun
`ifdef TASK_RESP_TIMEOUT_EN
   ,
   output logic              task_error
`endif
);

   // A zero stall limit would abort every burst before its first beat.
   if (TIMEOUT < 1) begin : gBadTimeout
      $error("task_responder: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT             state;
   stateT             stateNext;
   logic [LEN_W-1:0]  rem;        // beats still to send in this burst
   logic [DATA_W-1:0] cur;        // data value of the beat on offer
   logic              acceptTask; // start seen while idle
   logic              beatFire;   // stream handshake this cycle
   logic              lastBeat;   // the handshake consumes the final beat
   logic              abortBurst; // stall limit reached
   logic              busyQ;
   logic              doneQ;
   logic              validQ;
   logic              overrunQ;

   assign acceptTask = (state == IDLE) && task_start;
   assign beatFire   = validQ && out_ready;
   assign lastBeat   = beatFire && (rem == LEN_W'(1));

`ifdef TASK_RESP_TIMEOUT_EN
   // The counter holds 0..TIMEOUT-1. The abort fires on the stalled cycle
   // that would make it reach TIMEOUT.
   localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [STALL_W-1:0] stallCnt;
   logic               errorQ;

   assign abortBurst = (state == RUN) && !out_ready &&
                       (stallCnt == STALL_W'(TIMEOUT - 1));

   // Count consecutive stalled RUN cycles. Any accepted beat, or leaving
   // RUN, restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
      end else if ((state == RUN) && !out_ready) begin
         stallCnt <= stallCnt + STALL_W'(1);
      end else begin
         stallCnt <= '0;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         errorQ <= 1'b0;
      end else if (abortBurst) begin
         errorQ <= 1'b1;
      end
   end

   assign task_error = errorQ;
`else
   assign abortBurst = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic. A new task is accepted only in IDLE.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (task_start) begin
               stateNext = (task_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (lastBeat || abortBurst) begin
               stateNext = DONE;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Burst datapath: latch the task on accept, then step once per beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem <= '0;
         cur <= '0;
      end else if (acceptTask) begin
         rem <= task_len;
         cur <= task_seed;
      end else if (beatFire) begin
         rem <= rem - LEN_W'(1);
         cur <= cur + DATA_W'(1);
      end
   end

   // Status and valid outputs are registered from the next state, so they
   // always match the state register and never glitch. A stalled beat
   // holds valid and data because neither changes without a handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
         validQ <= 1'b0;
      end else begin
         busyQ  <= (stateNext != IDLE);
         doneQ  <= (stateNext == DONE);
         validQ <= (stateNext == RUN);
      end
   end

   // Sticky overrun flag: a start pulse that arrives while a task is in
   // flight, including the done cycle, is dropped but remembered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrunQ <= 1'b0;
      end else if (task_start && (state != IDLE)) begin
         overrunQ <= 1'b1;
      end
   end

   assign task_busy     = busyQ;
   assign task_done     = doneQ;
   assign out_valid     = validQ;
   assign out_data      = cur;
   assign start_overrun = overrunQ;

endmodule

// File: tb/tb_task_responder.sv
// Self-checking bench for task_responder. It runs a table of directed
// vectors, hand-written reset, backpressure and stall sequences, and a
// randomized run checked against a burst-level reference model.
module tb_task_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        task_start = 1'b0;
   logic [7:0]  task_len = '0;
   logic [15:0] task_seed = '0;
   logic        task_busy, task_done, out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        start_overrun;
`ifdef TASK_RESP_TIMEOUT_EN
   logic        task_error;
`endif

   int nChk  = 0;
   int nPass = 0;

   task_responder #(.LEN_W(8), .DATA_W(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .task_start(task_start), .task_len(task_len),
      .task_seed(task_seed), .task_busy(task_busy), .task_done(task_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .start_overrun(start_overrun)
`ifdef TASK_RESP_TIMEOUT_EN
      , .task_error(task_error)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
      nChk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else nPass++;
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output snapshot {busy, done, valid, data (masked unless valid), overrun}.
   function automatic logic [39:0] snap();
      return {19'd0, task_busy, task_done, out_valid,
              (out_valid ? out_data : 16'h0), start_overrun};
   endfunction

   function automatic logic [39:0] expSnap(input logic b, input logic d, input logic v,
                                           input logic [15:0] data, input logic ov);
      return {19'd0, b, d, v, (v ? data : 16'h0), ov};
   endfunction

   typedef struct {
      logic        start;
      logic [7:0]  len;
      logic [15:0] seed;
      logic        eBusy, eDone, eValid;
      logic [15:0] eData;
      logic        eOv;
   } vecT;

   function automatic vecT mk(input logic s, input logic [7:0] l, input logic [15:0] sd,
                              input logic b, input logic d, input logic v,
                              input logic [15:0] dt, input logic ov);
      vecT r;
      r.start = s; r.len = l; r.seed = sd;
      r.eBusy = b; r.eDone = d; r.eValid = v; r.eData = dt; r.eOv = ov;
      return r;
   endfunction

   // Reference model state, kept at the level of "task in flight, beats
   // left, next value, done owed".
   int mInTask, mLeft, mNext, mDoneNow, mOv;

   task automatic modelReset();
      mInTask = 0; mLeft = 0; mNext = 0; mDoneNow = 0; mOv = 0;
   endtask

   task automatic modelEdge(input int s, input int l, input int sd, input int rdy);
      if (mDoneNow != 0) begin
         mDoneNow = 0; mInTask = 0;
         if (s != 0) mOv = 1;
      end else if (mInTask != 0) begin
         if (s != 0) mOv = 1;
         if (rdy != 0) begin
            mNext = (mNext + 1) % 65536;
            mLeft = mLeft - 1;
            if (mLeft == 0) mDoneNow = 1;
         end
      end else if (s != 0) begin
         mInTask = 1; mLeft = l; mNext = sd;
         if (l == 0) mDoneNow = 1;
      end
   endtask

   initial begin
      vecT tbl[18];
      logic [15:0] bpD[6];
      logic        bpR[6];
      logic        hold;
      int          zeroRun;

      tbl[0]  = mk(1, 8'd4, 16'h00FE, 1, 0, 1, 16'h00FE, 0);
      tbl[1]  = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h00FF, 0);
      tbl[2]  = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h0100, 0);
      tbl[3]  = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h0101, 0);
      tbl[4]  = mk(0, 8'd0, 16'h0000, 1, 1, 0, 16'h0000, 0);
      tbl[5]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 16'h0000, 0);
      tbl[6]  = mk(1, 8'd0, 16'h1234, 1, 1, 0, 16'h0000, 0);
      tbl[7]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 16'h0000, 0);
      tbl[8]  = mk(1, 8'd5, 16'h0010, 1, 0, 1, 16'h0010, 0);
      tbl[9]  = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h0011, 0);
      tbl[10] = mk(1, 8'd7, 16'h0099, 1, 0, 1, 16'h0012, 1);
      tbl[11] = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h0013, 1);
      tbl[12] = mk(0, 8'd0, 16'h0000, 1, 0, 1, 16'h0014, 1);
      tbl[13] = mk(0, 8'd0, 16'h0000, 1, 1, 0, 16'h0000, 1);
      tbl[14] = mk(1, 8'd3, 16'h0077, 0, 0, 0, 16'h0000, 1);
      tbl[15] = mk(1, 8'd1, 16'h0020, 1, 0, 1, 16'h0020, 1);
      tbl[16] = mk(0, 8'd0, 16'h0000, 1, 1, 0, 16'h0000, 1);
      tbl[17] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 16'h0000, 1);

      // Reset state: every output must be zero, including the raw data bus.
      step(); step();
      chk("reset_outputs", {task_busy, task_done, out_valid, out_data, start_overrun}, 40'h0);
`ifdef TASK_RESP_TIMEOUT_EN
      chk("reset_error", {39'd0, task_error}, 40'h0);
`endif
      #2 rst = 1'b0;

      // Directed table: basic burst, zero length, overrun, then a recovery task.
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         task_start = tbl[i].start; task_len = tbl[i].len; task_seed = tbl[i].seed;
         step();
         chk($sformatf("table_row%0d", i), snap(),
             expSnap(tbl[i].eBusy, tbl[i].eDone, tbl[i].eValid, tbl[i].eData, tbl[i].eOv));
      end
      task_start = 1'b0;

      // Backpressure with data wrap.
      bpR = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bpD = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
      task_start = 1'b1; task_len = 8'd3; task_seed = 16'hFFFF;
      step();
      task_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp_beat%0d", i), snap(), expSnap(1, 0, 1, bpD[i], 1));
         out_ready = bpR[i];
         step();
      end
      chk("bp_done", snap(), expSnap(1, 1, 0, 16'h0, 1));
      step();
      chk("bp_idle", snap(), expSnap(0, 0, 0, 16'h0, 1));

      // Asynchronous reset in the middle of a burst.
      out_ready = 1'b1;
      task_start = 1'b1; task_len = 8'd10; task_seed = 16'h0040;
      step();
      task_start = 1'b0;
      step(); step(); step();
      chk("rst_pre", snap(), expSnap(1, 0, 1, 16'h0043, 1));
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {task_busy, task_done, out_valid, out_data, start_overrun}, 40'h0);
      step();
      chk("rst_hold", {task_busy, task_done, out_valid, out_data, start_overrun}, 40'h0);
      #2 rst = 1'b0;
      task_start = 1'b1; task_len = 8'd4; task_seed = 16'h00FE;
      step();
      task_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("post_rst_beat%0d", i), snap(), expSnap(1, 0, 1, 16'h00FE + 16'(i), 0));
         step();
      end
      chk("post_rst_done", snap(), expSnap(1, 1, 0, 16'h0, 0));
      step();
      chk("post_rst_idle", snap(), expSnap(0, 0, 0, 16'h0, 0));

      // Long stall after one accepted beat.
      task_start = 1'b1; task_len = 8'd4; task_seed = 16'h0500;
      step();
      task_start = 1'b0;
      chk("stall_first", snap(), expSnap(1, 0, 1, 16'h0500, 0));
      step();
      out_ready = 1'b0;
      chk("stall_second", snap(), expSnap(1, 0, 1, 16'h0501, 0));
`ifdef TASK_RESP_TIMEOUT_EN
      hold = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (!(out_valid && out_data == 16'h0501 && !task_done)) hold = 1'b0;
      end
      chk("timeout_hold7", {39'd0, hold}, 40'd1);
      step();
      chk("timeout_done", snap(), expSnap(1, 1, 0, 16'h0, 0));
      chk("timeout_error", {39'd0, task_error}, 40'd1);
      step();
      chk("timeout_idle", snap(), expSnap(0, 0, 0, 16'h0, 0));
      out_ready = 1'b1;
`else
      hold = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!(out_valid && out_data == 16'h0501 && !task_done && task_busy)) hold = 1'b0;
      end
      chk("no_timeout_hold", {39'd0, hold}, 40'd1);
      out_ready = 1'b1;
      step(); step(); step();
      chk("stall_release_done", snap(), expSnap(1, 1, 0, 16'h0, 0));
      step();
      chk("stall_release_idle", snap(), expSnap(0, 0, 0, 16'h0, 0));
`endif

      // Randomized traffic against the reference model. Stall runs are kept
      // short so the timeout build never aborts a burst here.
      #2 rst = 1'b1;
      step();
      #2 rst = 1'b0;
      modelReset();
      zeroRun = 0;
      for (int c = 0; c < 3000; c++) begin
         int s, l, sd, r;
         chk($sformatf("rand_cycle%0d", c), snap(),
             expSnap(mInTask != 0, mDoneNow != 0, (mInTask != 0) && (mDoneNow == 0),
                     16'(mNext), mOv != 0));
         s  = ($urandom_range(0, 5) == 0) ? 1 : 0;
         l  = ($urandom_range(0, 29) == 0) ? 255 : int'($urandom_range(0, 5));
         sd = int'($urandom_range(0, 65535));
         r  = ($urandom_range(0, 9) < 7) ? 1 : 0;
         if (zeroRun >= 4) r = 1;
         zeroRun = (r != 0) ? 0 : zeroRun + 1;
         task_start = s[0]; task_len = 8'(l); task_seed = 16'(sd); out_ready = r[0];
         step();
         modelEdge(s, l, sd, r);
      end
      task_start = 1'b0;

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
